// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns over a 128-bit state, one shared 32-bit column datapath
// time-shared across the four columns. Optional register after the column
// helper trades one extra cycle per column for a shorter combinational path.
module inv_mix_columns_seq #(
  parameter int unsigned PIPE_HELPER = 0,
  localparam int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned COL_W = 32;
  localparam int unsigned CNT_W = 2;
  localparam bit          PIPE  = (PIPE_HELPER != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic                bypass_q, bypass_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [COL_W-1:0]    pipe_q, pipe_d;
  logic                phase_q, phase_d;
  logic [COL_W-1:0]    col_word;
  logic [COL_W-1:0]    helper_out;
  logic [COL_W-1:0]    wb_word;

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (covers 09/0b/0d/0e)
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^
           (k[1] ? b2 : 8'h00) ^ (k[0] ? b  : 8'h00);
  endfunction

  // One column of InvMixColumns, row 0 in the top byte
  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // Select the column being processed (column 0 is the top word)
  always_comb begin
    col_word = data_q[127:96];
    case (col_q)
      2'd0:    col_word = data_q[127:96];
      2'd1:    col_word = data_q[95:64];
      2'd2:    col_word = data_q[63:32];
      default: col_word = data_q[31:0];
    endcase
  end

  assign helper_out = inv_mix_col(col_word);
  assign wb_word    = PIPE ? pipe_q : helper_out;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    bypass_d = bypass_q;
    data_d   = data_q;
    pipe_d   = pipe_q;
    phase_d  = phase_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          col_d    = '0;
          bypass_d = in_bypass;
          phase_d  = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bypass_q) begin
          state_d = DONE;
        end else if (PIPE && !phase_q) begin
          pipe_d  = helper_out;
          phase_d = 1'b1;
        end else begin
          case (col_q)
            2'd0:    data_d[127:96] = wb_word;
            2'd1:    data_d[95:64]  = wb_word;
            2'd2:    data_d[63:32]  = wb_word;
            default: data_d[31:0]   = wb_word;
          endcase
          phase_d = 1'b0;
          col_d   = col_q + CNT_W'(1);
          if (col_q == CNT_W'(3)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      bypass_q <= 1'b0;
      data_q   <= '0;
      pipe_q   <= '0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      bypass_q <= bypass_d;
      data_q   <= data_d;
      pipe_q   <= pipe_d;
      phase_q  <= phase_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: instance 0 without and instance 1
// with the helper pipeline register, checked against known AES vectors.
module tb_inv_mix_columns_seq;

  localparam logic [127:0] VEC_A_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_A_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B_IN  = 128'h046681e5_e0cb199a_9fdc589d_8e4da1bc;
  localparam logic [127:0] VEC_B_OUT = 128'hd4bf5d30_e0b452ae_f20a225c_db135345;
  localparam logic [127:0] VEC_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic              clk;
  logic              rst;
  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [1:0][127:0] in_data;
  logic [1:0]        in_bypass;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [1:0][127:0] out_data;
  logic [1:0]        busy;

  int checks;
  int errors;

  inv_mix_columns_seq #(.PIPE_HELPER(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_bypass(in_bypass[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  inv_mix_columns_seq #(.PIPE_HELPER(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_bypass(in_bypass[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one edge, then drop in_valid
  task automatic send(input int d, input logic [127:0] data, input logic byp);
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    in_bypass[d] = byp;
    tick();
    in_valid[d]  = 1'b0;
  endtask

  // Cycles from the accept edge to the first out_valid; 0 means timeout
  task automatic wait_valid(input int d, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid[d] === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
      checks++;
      if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
      checks++;
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
      checks++;
      if (out_data[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", d, out_data[d]); end
    end
  endtask

  task automatic test_vector(input int d, input int lat, input logic [127:0] din,
                             input logic [127:0] dexp);
    int cyc;
    out_ready[d] = 1'b1;
    checks++;
    if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL vec_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
    send(d, din, 1'b0);
    checks++;
    if (busy[d] !== 1'b1) begin errors++; $display("FAIL vec_busy[%0d]: got %b want 1", d, busy[d]); end
    wait_valid(d, cyc);
    checks++;
    if (cyc !== lat) begin errors++; $display("FAIL vec_latency[%0d]: got %0d want %0d", d, cyc, lat); end
    checks++;
    if (out_data[d] !== dexp) begin errors++; $display("FAIL vec_data[%0d]: got %h want %h", d, out_data[d], dexp); end
    tick();
    checks++;
    if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL vec_one_cycle[%0d]: got %b want 0", d, out_valid[d]); end
    checks++;
    if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL vec_back_idle[%0d]: got %b want 1", d, in_ready[d]); end
  endtask

  task automatic test_bypass();
    int cyc;
    out_ready[0] = 1'b1;
    send(0, VEC_BYP, 1'b1);
    in_bypass[0] = 1'b0;
    wait_valid(0, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL bypass_latency: got %0d want 1", cyc); end
    checks++;
    if (out_data[0] !== VEC_BYP) begin errors++; $display("FAIL bypass_data: got %h want %h", out_data[0], VEC_BYP); end
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bypass_one_cycle: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_stall();
    int cyc;
    out_ready[0] = 1'b0;
    send(0, VEC_A_IN, 1'b0);
    wait_valid(0, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", cyc); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL stall_valid cyc%0d: got %b want 1", i, out_valid[0]); end
      checks++;
      if (out_data[0] !== VEC_A_OUT) begin errors++; $display("FAIL stall_data cyc%0d: got %h want %h", i, out_data[0], VEC_A_OUT); end
      checks++;
      if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc%0d: got %b want 0", i, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", out_valid[0]); end
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready[0]); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = VEC_B_IN;
    in_bypass[0] = 1'b0;
    tick();
    // Second word presented right after the accept, with bypass flipped
    in_data[0]   = VEC_BYP;
    in_bypass[0] = 1'b1;
    wait_valid(0, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", cyc); end
    checks++;
    if (out_data[0] !== VEC_B_OUT) begin errors++; $display("FAIL b2b_first_data: got %h want %h", out_data[0], VEC_B_OUT); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready cyc%0d: got %b want 0", i, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    tick();
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready[0]); end
    tick();
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b want 0", in_ready[0]); end
    tick();
    checks++;
    if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", out_valid[0]); end
    checks++;
    if (out_data[0] !== VEC_BYP) begin errors++; $display("FAIL b2b_second_data: got %h want %h", out_data[0], VEC_BYP); end
    tick();
    in_bypass[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready[0] = 1'b1;
    send(0, VEC_A_IN, 1'b0);
    tick();
    tick();
    checks++;
    if (u0.col_q !== 2'd2) begin errors++; $display("FAIL rstmid_col: got %0d want 2", u0.col_q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready[0]); end
    checks++;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid[0]); end
    checks++;
    if (out_data[0] !== 128'h0) begin errors++; $display("FAIL rstmid_out_data: got %h want 0", out_data[0]); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_stale_valid: got %0d cycles want 0", seen); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_bypass = '0;
    out_ready = '0;
    test_reset();
    test_vector(0, 4, VEC_A_IN, VEC_A_OUT);
    test_vector(1, 8, VEC_A_IN, VEC_A_OUT);
    test_vector(0, 4, VEC_B_IN, VEC_B_OUT);
    test_vector(1, 8, VEC_B_IN, VEC_B_OUT);
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
